// File: rtl/tage_update_queue.sv
// tage_update_queue
//   Update-side initiator for the TAGE predictor. Each prediction made at
//   fetch (index, predicted direction, predicted target, domain) is recorded
//   in a FIFO. In-order branch resolutions from execute are matched against
//   the FIFO head. The predictor update port is driven one cycle after each
//   resolution.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   pred_valid_i/ready_o     fetch-side push handshake (ready = not full)
//   pred_idx/taken/targ/domain_i  prediction record to store
//   res_valid/taken/targ_i   resolution of the oldest in-flight branch
//   flush_i                  squash all unresolved entries
//   update_en_o ... domain_o registered predictor update port
//   count_o                  current occupancy
//   res_err_o                one-cycle pulse: resolve seen with queue empty
module tage_update_queue #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 32,
    parameter int TARG_W = 32,
    parameter int DOM_W  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     pred_valid_i,
    output logic                     pred_ready_o,
    input  logic [IDX_W-1:0]         pred_idx_i,
    input  logic                     pred_taken_i,
    input  logic [TARG_W-1:0]        pred_targ_i,
    input  logic [DOM_W-1:0]         pred_domain_i,
    input  logic                     res_valid_i,
    input  logic                     res_taken_i,
    input  logic [TARG_W-1:0]        res_targ_i,
    input  logic                     flush_i,
    output logic                     update_en_o,
    output logic                     br_result_o,
    output logic                     correct_o,
    output logic [IDX_W-1:0]         idx_o,
    output logic [TARG_W-1:0]        targ_o,
    output logic [DOM_W-1:0]         domain_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     res_err_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;

    logic [IDX_W-1:0]  idx_mem   [DEPTH];
    logic              taken_mem [DEPTH];
    logic [TARG_W-1:0] targ_mem  [DEPTH];
    logic [DOM_W-1:0]  dom_mem   [DEPTH];

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;
    logic head_taken;
    logic [TARG_W-1:0] head_targ;
    logic head_correct;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign pred_ready_o = !full;
    assign count_o      = wr_ptr - rd_ptr;

    // A flush squashes the same-cycle enqueue; the same-cycle resolve still pops.
    assign do_push = pred_valid_i && !full && !flush_i;
    assign do_pop  = res_valid_i && !empty;

    assign head_taken   = taken_mem[rd_ptr[AW-1:0]];
    assign head_targ    = targ_mem[rd_ptr[AW-1:0]];
    // Target only matters when the branch was actually taken.
    assign head_correct = (head_taken == res_taken_i) &&
                          (!res_taken_i || (head_targ == res_targ_i));

    assign rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            if (flush_i) begin
                wr_ptr <= rd_ptr_nxt;
            end else if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
        end
    end

    // Entry storage carries no reset; validity is defined by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            idx_mem[wr_ptr[AW-1:0]]   <= pred_idx_i;
            taken_mem[wr_ptr[AW-1:0]] <= pred_taken_i;
            targ_mem[wr_ptr[AW-1:0]]  <= pred_targ_i;
            dom_mem[wr_ptr[AW-1:0]]   <= pred_domain_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            update_en_o <= 1'b0;
            br_result_o <= 1'b0;
            correct_o   <= 1'b0;
            idx_o       <= '0;
            targ_o      <= '0;
            domain_o    <= '0;
            res_err_o   <= 1'b0;
        end else begin
            update_en_o <= do_pop;
            res_err_o   <= res_valid_i && empty;
            if (do_pop) begin
                br_result_o <= res_taken_i;
                correct_o   <= head_correct;
                idx_o       <= idx_mem[rd_ptr[AW-1:0]];
                targ_o      <= res_targ_i;
                domain_o    <= dom_mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_tage_update_queue.sv
module tb_tage_update_queue;

    localparam int DEPTH  = 8;
    localparam int IDX_W  = 32;
    localparam int TARG_W = 32;
    localparam int DOM_W  = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              pred_valid_i;
    logic              pred_ready_o;
    logic [IDX_W-1:0]  pred_idx_i;
    logic              pred_taken_i;
    logic [TARG_W-1:0] pred_targ_i;
    logic [DOM_W-1:0]  pred_domain_i;
    logic              res_valid_i;
    logic              res_taken_i;
    logic [TARG_W-1:0] res_targ_i;
    logic              flush_i;
    logic              update_en_o;
    logic              br_result_o;
    logic              correct_o;
    logic [IDX_W-1:0]  idx_o;
    logic [TARG_W-1:0] targ_o;
    logic [DOM_W-1:0]  domain_o;
    logic [3:0]        count_o;
    logic              res_err_o;

    tage_update_queue #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .TARG_W(TARG_W), .DOM_W(DOM_W)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o),
        .pred_idx_i(pred_idx_i), .pred_taken_i(pred_taken_i),
        .pred_targ_i(pred_targ_i), .pred_domain_i(pred_domain_i),
        .res_valid_i(res_valid_i), .res_taken_i(res_taken_i),
        .res_targ_i(res_targ_i), .flush_i(flush_i),
        .update_en_o(update_en_o), .br_result_o(br_result_o),
        .correct_o(correct_o), .idx_o(idx_o), .targ_o(targ_o),
        .domain_o(domain_o), .count_o(count_o), .res_err_o(res_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic              taken;
        logic [TARG_W-1:0] targ;
        logic [DOM_W-1:0]  dom;
    } ent_t;

    typedef struct {
        logic              br;
        logic              corr;
        logic [IDX_W-1:0]  idx;
        logic [TARG_W-1:0] targ;
        logic [DOM_W-1:0]  dom;
    } upd_t;

    ent_t model_q[$];
    upd_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, then check after the edge.
    task automatic step(input logic pv, input logic [IDX_W-1:0] pidx, input logic ptk,
                        input logic [TARG_W-1:0] ptg, input logic [DOM_W-1:0] pdom,
                        input logic rv, input logic rtk, input logic [TARG_W-1:0] rtg,
                        input logic fl);
        logic exp_upd;
        logic exp_err;
        logic was_full;
        ent_t e;
        upd_t u;
        pred_valid_i  = pv;
        pred_idx_i    = pidx;
        pred_taken_i  = ptk;
        pred_targ_i   = ptg;
        pred_domain_i = pdom;
        res_valid_i   = rv;
        res_taken_i   = rtk;
        res_targ_i    = rtg;
        flush_i       = fl;
        exp_upd  = 1'b0;
        exp_err  = 1'b0;
        was_full = (model_q.size() == DEPTH);
        if (rv) begin
            if (model_q.size() > 0) begin
                e = model_q.pop_front();
                u.br   = rtk;
                u.corr = (e.taken == rtk) && (!rtk || e.targ == rtg);
                u.idx  = e.idx;
                u.targ = rtg;
                u.dom  = e.dom;
                exp_q.push_back(u);
                exp_upd = 1'b1;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (pv && !was_full && !fl) begin
            e.idx = pidx; e.taken = ptk; e.targ = ptg; e.dom = pdom;
            model_q.push_back(e);
        end
        if (fl) model_q.delete();
        @(posedge clk_i);
        #1;
        chk("update_en", 64'(update_en_o), 64'(exp_upd));
        chk("res_err", 64'(res_err_o), 64'(exp_err));
        chk("count", 64'(count_o), 64'(model_q.size()));
        chk("ready", 64'(pred_ready_o), 64'(model_q.size() != DEPTH));
        if (exp_upd) begin
            u = exp_q.pop_front();
            chk("br_result", 64'(br_result_o), 64'(u.br));
            chk("correct", 64'(correct_o), 64'(u.corr));
            chk("idx", 64'(idx_o), 64'(u.idx));
            chk("targ", 64'(targ_o), 64'(u.targ));
            chk("domain", 64'(domain_o), 64'(u.dom));
        end
    endtask

    task automatic push(input logic [IDX_W-1:0] idx, input logic tk,
                        input logic [TARG_W-1:0] tg, input logic [DOM_W-1:0] d);
        step(1'b1, idx, tk, tg, d, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic resolve(input logic tk, input logic [TARG_W-1:0] tg);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1, tk, tg, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst_ni = 1'b0;
        pred_valid_i = 0; pred_idx_i = '0; pred_taken_i = 0; pred_targ_i = '0;
        pred_domain_i = '0; res_valid_i = 0; res_taken_i = 0; res_targ_i = '0;
        flush_i = 0;
        #12;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_ready", 64'(pred_ready_o), 64'd1);
        chk("rst_upd", 64'(update_en_o), 64'd0);
        chk("rst_err", 64'(res_err_o), 64'd0);
        chk("rst_idx", 64'(idx_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        idle();

        // Basic correct prediction
        push(32'h10, 1'b1, 32'h400, 2'd1);
        resolve(1'b1, 32'h400);
        idle();

        // Target mismatch, then not-taken with arbitrary target
        push(32'h20, 1'b1, 32'h400, 2'd2);
        resolve(1'b1, 32'h500);
        push(32'h30, 1'b0, 32'h0, 2'd3);
        resolve(1'b0, 32'h1234);
        // Direction mismatch
        push(32'h40, 1'b0, 32'h0, 2'd0);
        resolve(1'b1, 32'h0);

        // Fill, overflow drop, drain in order
        for (int i = 0; i < DEPTH; i++) push(32'h100 + i, i[0], 32'h800 + i, i[1:0]);
        push(32'hDEAD, 1'b1, 32'hBEEF, 2'd3);
        for (int i = 0; i < DEPTH; i++) resolve(i[0], 32'h800 + i);
        idle();

        // Full: push+resolve same cycle only resolves
        for (int i = 0; i < DEPTH; i++) push(32'h200 + i, 1'b1, 32'h900, 2'd1);
        step(1'b1, 32'hAAAA, 1'b0, '0, '0, 1'b1, 1'b1, 32'h900, 1'b0);
        while (model_q.size() > 0) resolve(1'b1, 32'h900);

        // Simultaneous push/resolve at count 3 across pointer wrap
        for (int i = 0; i < 3; i++) push(32'h300 + i, 1'b1, 32'hA00, 2'd2);
        for (int i = 0; i < 20; i++) begin
            logic tk;
            tk = 1'($urandom_range(0, 1));
            step(1'b1, 32'h400 + i, tk, 32'hA00 + (i % 3), 2'(i),
                 1'b1, 1'($urandom_range(0, 1)), 32'hA00 + ($urandom_range(0, 1)), 1'b0);
        end
        while (model_q.size() > 0) resolve(1'b1, 32'hA00);

        // Flush with same-cycle resolve and push at count 5
        for (int i = 0; i < 5; i++) push(32'h500 + i, 1'b0, '0, 2'd1);
        step(1'b1, 32'h5FF, 1'b1, 32'h1, 2'd0, 1'b1, 1'b0, 32'h0, 1'b1);
        idle();
        push(32'h600, 1'b1, 32'hC00, 2'd3);
        resolve(1'b1, 32'hC00);

        // Resolve while empty
        resolve(1'b1, 32'h0);
        idle();

        // Async reset with an update pending in the output register
        push(32'h700, 1'b1, 32'hD00, 2'd1);
        push(32'h701, 1'b1, 32'hD00, 2'd1);
        resolve(1'b1, 32'hD00);
        #2;
        rst_ni = 1'b0;
        #1;
        model_q.delete();
        exp_q.delete();
        chk("arst_upd", 64'(update_en_o), 64'd0);
        chk("arst_count", 64'(count_o), 64'd0);
        chk("arst_ready", 64'(pred_ready_o), 64'd1);
        chk("arst_idx", 64'(idx_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        idle();
        push(32'h800, 1'b1, 32'hE00, 2'd2);
        resolve(1'b1, 32'hE00);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
